// File: rtl/memory_arbiter_pkg.sv
// Shared memory-bus types: address type, arbiter FSM states and grant identifiers.
package memory_arbiter_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_e;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_e;

endpackage

// File: rtl/memory_arbiter.sv
// Round-robin arbiter of I/D cache ports onto one memory port; request at edge N drives memory from N+1.
// Requests are taken only in IDLE with m_ready high; the winner's command is held until m_done.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int BUS_WIDTH_BYTES = 256,
  parameter int BUS_WIDTH_BITS  = BUS_WIDTH_BYTES * 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         i_address,
  input  logic                      i_read,
  input  logic                      i_write,
  input  logic [BUS_WIDTH_BITS-1:0] i_data_w,
  output logic [BUS_WIDTH_BITS-1:0] i_data_r,
  output logic                      i_ready,
  output logic                      i_done,
  input  logic [ADDR_W-1:0]         d_address,
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [BUS_WIDTH_BITS-1:0] d_data_w,
  output logic [BUS_WIDTH_BITS-1:0] d_data_r,
  output logic                      d_ready,
  output logic                      d_done,
  output logic [ADDR_W-1:0]         m_address,
  output logic                      m_read,
  output logic                      m_write,
  output logic [BUS_WIDTH_BITS-1:0] m_data_w,
  input  logic [BUS_WIDTH_BITS-1:0] m_data_r,
  input  logic                      m_ready,
  input  logic                      m_done,
  output logic                      err
);

  arb_state_e                state_q, state_d;
  grant_e                    last_q, last_d;
  logic                      m_read_q, m_read_d;
  logic                      m_write_q, m_write_d;
  addr_t                     m_address_q, m_address_d;
  logic [BUS_WIDTH_BITS-1:0] m_data_w_q, m_data_w_d;
  logic                      err_q, err_d;

  logic req_i, req_d, pick_d;

  assign req_i  = i_read | i_write;
  assign req_d  = d_read | d_write;
  // D wins when it is the only requester, or on a tie when I was granted last.
  assign pick_d = req_d & (~req_i | (last_q == GRANT_I));

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    m_read_d    = m_read_q;
    m_write_d   = m_write_q;
    m_address_d = m_address_q;
    m_data_w_d  = m_data_w_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = m_done;
        if (m_ready && (req_i || req_d)) begin
          if (pick_d) begin
            state_d     = SERVE_D;
            last_d      = GRANT_D;
            m_address_d = d_address;
            m_data_w_d  = d_data_w;
            m_write_d   = d_write;
            m_read_d    = d_read & ~d_write;
            err_d       = m_done | (d_read & d_write);
          end else begin
            state_d     = SERVE_I;
            last_d      = GRANT_I;
            m_address_d = i_address;
            m_data_w_d  = i_data_w;
            m_write_d   = i_write;
            m_read_d    = i_read & ~i_write;
            err_d       = m_done | (i_read & i_write);
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (m_done) begin
          state_d   = RELEASE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        err_d   = m_done;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= GRANT_D;
      m_read_q    <= 1'b0;
      m_write_q   <= 1'b0;
      m_address_q <= '0;
      m_data_w_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      m_read_q    <= m_read_d;
      m_write_q   <= m_write_d;
      m_address_q <= m_address_d;
      m_data_w_q  <= m_data_w_d;
      err_q       <= err_d;
    end
  end

  // Ready is masked by reset since state alone reads IDLE while reset is held.
  assign i_ready   = ~reset & (state_q == IDLE) & m_ready;
  assign d_ready   = ~reset & (state_q == IDLE) & m_ready;
  assign i_done    = (state_q == SERVE_I) & m_done;
  assign d_done    = (state_q == SERVE_D) & m_done;
  assign i_data_r  = (state_q == SERVE_I) ? m_data_r : '0;
  assign d_data_r  = (state_q == SERVE_D) ? m_data_r : '0;
  assign m_read    = m_read_q;
  assign m_write   = m_write_q;
  assign m_address = m_address_q;
  assign m_data_w  = m_data_w_q;
  assign err       = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: single grants, ties, fairness, protocol errors, reset abort, backpressure.
module tb_memory_arbiter;

  localparam int BW = 2048;

  logic          clk, reset;
  logic [31:0]   i_address, d_address, m_address;
  logic          i_read, i_write, d_read, d_write;
  logic [BW-1:0] i_data_w, d_data_w, i_data_r, d_data_r, m_data_w, m_data_r;
  logic          i_ready, i_done, d_ready, d_done;
  logic          m_read, m_write, m_ready, m_done, err;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] pat_a5, pat_5a, pat_3c, zero_w;

  memory_arbiter dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_write(i_write), .i_data_w(i_data_w),
    .i_data_r(i_data_r), .i_ready(i_ready), .i_done(i_done),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_data_w(d_data_w),
    .d_data_r(d_data_r), .d_ready(d_ready), .d_done(d_done),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_data_w(m_data_w),
    .m_data_r(m_data_r), .m_ready(m_ready), .m_done(m_done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed low64 %h expected low64 %h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  initial begin
    pat_a5 = {256{8'hA5}};
    pat_5a = {256{8'h5A}};
    pat_3c = {256{8'h3C}};
    zero_w = '0;
    reset = 1'b1;
    i_address = '0; i_read = 1'b0; i_write = 1'b0; i_data_w = '0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_data_w = '0;
    m_data_r = '0; m_ready = 1'b1; m_done = 1'b0;

    // Reset state
    #3;
    chk1("rst_m_read", m_read, 1'b0);
    chk1("rst_m_write", m_write, 1'b0);
    chk32("rst_m_address", m_address, 32'h0);
    chkw("rst_m_data_w", m_data_w, zero_w);
    chk1("rst_i_ready", i_ready, 1'b0);
    chk1("rst_d_ready", d_ready, 1'b0);
    chk1("rst_err", err, 1'b0);
    cyc();
    reset = 1'b0;

    // Lone I read, memory done in the 5th cycle of m_read
    i_address = 32'h0000_1000; i_read = 1'b1;
    #1;
    chk1("t1_i_ready", i_ready, 1'b1);
    chk1("t1_mread_pre", m_read, 1'b0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk1("t1_mread_hold", m_read, 1'b1);
      chk1("t1_i_done_early", i_done, 1'b0);
      cyc();
    end
    m_done = 1'b1; m_data_r = pat_a5;
    #1;
    chk1("t1_mread_5th", m_read, 1'b1);
    chk32("t1_m_address", m_address, 32'h0000_1000);
    chk1("t1_i_done", i_done, 1'b1);
    chkw("t1_i_data_r", i_data_r, pat_a5);
    chk1("t1_d_done", d_done, 1'b0);
    chkw("t1_d_data_r", d_data_r, zero_w);
    cyc();
    m_done = 1'b0; m_data_r = '0; i_read = 1'b0;
    #1;
    chk1("t1_mread_drop", m_read, 1'b0);
    chk1("t1_i_done_once", i_done, 1'b0);
    chk1("t1_release_rdy", i_ready, 1'b0);
    cyc();

    // Tie after reset: I first, then D without D re-asserting
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_3000;
    d_write = 1'b1; d_address = 32'h0000_2000; d_data_w = pat_5a;
    cyc();
    chk1("t2_i_m_read", m_read, 1'b1);
    chk1("t2_i_m_write", m_write, 1'b0);
    chk32("t2_i_addr", m_address, 32'h0000_3000);
    cyc();
    m_done = 1'b1; m_data_r = pat_3c;
    #1;
    chk1("t2_i_done", i_done, 1'b1);
    chk1("t2_d_done_early", d_done, 1'b0);
    cyc();
    m_done = 1'b0; i_read = 1'b0;
    #1;
    chk1("t2_release_d_rdy", d_ready, 1'b0);
    chk1("t2_release_m_write", m_write, 1'b0);
    cyc();
    chk1("t2_idle_d_rdy", d_ready, 1'b1);
    cyc();
    chk1("t2_d_m_write", m_write, 1'b1);
    chk1("t2_d_m_read", m_read, 1'b0);
    chk32("t2_d_addr", m_address, 32'h0000_2000);
    chkw("t2_d_data_w", m_data_w, pat_5a);
    m_done = 1'b1;
    #1;
    chk1("t2_d_done", d_done, 1'b1);
    chk1("t2_i_done_none", i_done, 1'b0);
    cyc();
    m_done = 1'b0; d_write = 1'b0;
    cyc();

    // Fairness: four ties alternate I, D, I, D
    for (int r = 0; r < 4; r++) begin
      i_read = 1'b1; i_address = 32'h0000_0100 + 32'(r);
      d_read = 1'b1; d_address = 32'h0000_0200 + 32'(r);
      cyc();
      chk32("t3_grant_addr", m_address, (r % 2 == 0) ? 32'h0000_0100 + 32'(r) : 32'h0000_0200 + 32'(r));
      m_done = 1'b1;
      #1;
      chk1("t3_i_done", i_done, (r % 2 == 0));
      chk1("t3_d_done", d_done, (r % 2 != 0));
      cyc();
      m_done = 1'b0; i_read = 1'b0; d_read = 1'b0;
      cyc();
    end

    // Protocol errors: read+write on D, then a stray m_done in IDLE
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_4000;
    cyc();
    chk1("t4_m_write", m_write, 1'b1);
    chk1("t4_m_read", m_read, 1'b0);
    chk1("t4_err_pulse", err, 1'b1);
    cyc();
    chk1("t4_err_once", err, 1'b0);
    m_done = 1'b1;
    #1;
    chk1("t4_d_done", d_done, 1'b1);
    cyc();
    m_done = 1'b0; d_read = 1'b0; d_write = 1'b0;
    #1;
    chk1("t4_err_quiet", err, 1'b0);
    cyc();
    m_done = 1'b1;
    #1;
    chk1("t4_stray_i_done", i_done, 1'b0);
    chk1("t4_stray_d_done", d_done, 1'b0);
    cyc();
    m_done = 1'b0;
    #1;
    chk1("t4_stray_err", err, 1'b1);
    chk1("t4_stray_no_mread", m_read, 1'b0);
    cyc();
    chk1("t4_stray_err_once", err, 1'b0);

    // Reset two cycles into a D write aborts it
    d_write = 1'b1; d_address = 32'h0000_5000; d_data_w = pat_5a;
    cyc();
    chk1("t5_m_write", m_write, 1'b1);
    cyc();
    chk1("t5_d_done_n1", d_done, 1'b0);
    cyc();
    chk1("t5_d_done_n2", d_done, 1'b0);
    reset = 1'b1;
    #1;
    chk1("t5_abort_m_write", m_write, 1'b0);
    chk1("t5_abort_d_done", d_done, 1'b0);
    chk1("t5_abort_d_ready", d_ready, 1'b0);
    chk32("t5_abort_addr", m_address, 32'h0);
    cyc();
    reset = 1'b0; d_write = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_7000;
    d_read = 1'b1; d_address = 32'h0000_7100;
    cyc();
    chk1("t5_tie_m_read", m_read, 1'b1);
    chk32("t5_tie_addr", m_address, 32'h0000_7000);
    m_done = 1'b1;
    #1;
    chk1("t5_i_done", i_done, 1'b1);
    chk1("t5_d_done", d_done, 1'b0);
    cyc();
    m_done = 1'b0; i_read = 1'b0; d_read = 1'b0;
    cyc();

    // Backpressure: m_ready low holds off the grant
    m_ready = 1'b0; i_read = 1'b1; i_address = 32'h0000_6000;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk1("t6_bp_i_ready", i_ready, 1'b0);
      chk1("t6_bp_m_read", m_read, 1'b0);
      cyc();
    end
    m_ready = 1'b1;
    #1;
    chk1("t6_i_ready", i_ready, 1'b1);
    chk1("t6_m_read_pre", m_read, 1'b0);
    cyc();
    chk1("t6_m_read", m_read, 1'b1);
    chk32("t6_addr", m_address, 32'h0000_6000);
    m_done = 1'b1;
    #1;
    chk1("t6_i_done", i_done, 1'b1);
    cyc();
    m_done = 1'b0; i_read = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The parameter BUS_WIDTH_BYTES SHALL default to 256 and set the line width in bytes.
REQ-002 The parameter BUS_WIDTH_BITS SHALL default to BUS_WIDTH_BYTES*8 and set the data width.
REQ-003 The port clk SHALL be an input of 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 The port reset SHALL be an input of 1 bit: asynchronous, active-high reset.
REQ-005 The ports i_address (input, 32), i_read (input, 1), i_write (input, 1) and i_data_w (input, BUS_WIDTH_BITS) SHALL form the instruction-cache request.
REQ-006 The ports i_data_r (output, BUS_WIDTH_BITS), i_ready (output, 1) and i_done (output, 1) SHALL form the instruction-cache response.
REQ-007 The ports d_address, d_read, d_write, d_data_w, d_data_r, d_ready and d_done SHALL form the data-cache port, with the same directions and widths as the i_ ports.
REQ-008 The ports m_address (output, 32), m_read (output, 1), m_write (output, 1) and m_data_w (output, BUS_WIDTH_BITS) SHALL form the memory-side request.
REQ-009 The ports m_data_r (input, BUS_WIDTH_BITS), m_ready (input, 1) and m_done (input, 1) SHALL form the memory-side response.
REQ-010 The port err SHALL be an output of 1 bit: a one-cycle pulse flagging a protocol violation.

Function
REQ-011 The FSM SHALL have the states IDLE, SERVE_I, SERVE_D and RELEASE.
REQ-012 A request SHALL exist on a port when its read or write is high; it is sampled in IDLE only when m_ready=1.
REQ-013 If only one port requests, that port SHALL be granted.
REQ-014 If both ports request, the port not granted last SHALL win (round-robin); the last-grant register is updated at every grant.
REQ-015 On grant, the winner's address, write data and operation SHALL be latched, and the FSM SHALL enter SERVE_I or SERVE_D.
REQ-016 m_read, m_write, m_address and m_data_w SHALL be registered, driven from the latch one cycle after the sampling edge, and held stable until m_done.
REQ-017 In SERVE_x, m_done and m_data_r SHALL pass combinationally to x_done and x_data_r in the same cycle; the non-granted port sees done=0 and data_r=0.
REQ-018 On m_done in SERVE_x, m_read and m_write SHALL drop at the next edge, and the FSM SHALL enter RELEASE for exactly one cycle before returning to IDLE.
REQ-019 Latency: a request accepted at edge N SHALL produce m_read or m_write high from N+1; the best-case port-to-port turnaround is 3 cycles of overhead beyond memory latency.
REQ-020 x_ready SHALL be high only when state=IDLE and m_ready=1.
REQ-021 The requester is required to hold its request until x_done and to drop it the cycle after; the arbiter ignores a requester change after grant (the latched values stay in use).
REQ-022 If read and write are both high on the winning port, the operation SHALL be treated as write, and err SHALL pulse for one cycle.
REQ-023 m_done while in IDLE or RELEASE SHALL be ignored, and err SHALL pulse for one cycle.
REQ-024 A request still asserted in RELEASE SHALL NOT be re-granted until IDLE; this enforces the required drop of the request after x_done.

Reset
REQ-025 Reset SHALL asynchronously force state=IDLE, last-grant=D (so I wins the first tie) and the latches to 0.
REQ-026 While reset is asserted, m_read, m_write, m_address, m_data_w, i_/d_ready, i_/d_done, i_/d_data_r and err SHALL all read 0.
REQ-027 Reset mid-transaction SHALL abort the transaction with no done pulse; memory sees m_read and m_write fall immediately.

Structure
REQ-028 The FSM state enum and a grant enum (GRANT_I, GRANT_D) SHALL live in the shared package alongside the other memory-bus typedefs.
REQ-029 The block SHALL be a single module with no sub-modules; the round-robin pick is inline logic.

Verification
REQ-030 The bench SHALL cover a lone I read: i_read, addr 0x0000_1000, memory done after 4 cycles with data 0xA5 pattern -> i_done for one cycle carrying 0xA5 pattern, d_done=0, m_read high for 5 cycles.
REQ-031 The bench SHALL cover a tie after reset: i_read and d_write in the same cycle -> I served first, then D (addr 0x2000, data 0x5A) served without D re-asserting.
REQ-032 The bench SHALL cover fairness: both ports requesting back-to-back four times -> grants alternate I,D,I,D.
REQ-033 The bench SHALL cover a protocol error: d_read=d_write=1 -> m_write=1, m_read=0, err pulses once; a stray m_done in IDLE -> err pulses, no x_done.
REQ-034 The bench SHALL cover reset mid-SERVE_D: reset asserted 2 cycles after grant -> m_write=0 immediately, d_done never pulses, and the next tie grants I.
REQ-035 The bench SHALL cover backpressure: m_ready=0 with i_read held for 6 cycles -> i_ready=0 and no m_read; m_ready rises -> m_read asserted on the following cycle.
